// File: rtl/sub_bytes_iter_if.sv
// Valid/ready handshake bundle for the iterative SubBytes engine.
// The master presents blocks and consumes results. The slave is the engine.
interface sub_bytes_iter_if #(
    parameter int SIZE = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [SIZE*8-1:0] block;
    logic              inv;
    logic              out_valid;
    logic              out_ready;
    logic [SIZE*8-1:0] subed_block;

    modport master (
        output in_valid, block, inv, out_ready,
        input  in_ready, out_valid, subed_block
    );

    modport slave (
        input  in_valid, block, inv, out_ready,
        output in_ready, out_valid, subed_block
    );
endinterface

// File: rtl/sub_bytes_iter.sv
// Multi-cycle AES SubBytes/InvSubBytes engine: LANES S-boxes substitute a SIZE-byte block
// over SIZE/LANES beats, with valid/ready handshakes on both sides.
module sub_bytes_iter #(
    parameter int SIZE  = 16,
    parameter int LANES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    sub_bytes_iter_if.slave  bus
);
    localparam int BEATS = SIZE / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((LANES < 1) || (SIZE % LANES != 0)) begin : g_badLanes
        $error("sub_bytes_iter: LANES must be >= 1 and divide SIZE");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [CW-1:0]     r_cnt;
    logic [SIZE*8-1:0] r_data;
    logic [SIZE*8-1:0] r_result;
    logic              r_mode;
    logic              w_inReady;
    logic              w_outValid;
    logic              w_accept;
    logic              w_lastBeat;
    logic [7:0]        w_laneIn  [LANES];
    logic [7:0]        w_laneOut [LANES];

    // GF(2^8) arithmetic modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gfMul(p, p);
            r = gfMul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic mode, input logic [7:0] x);
        logic [7:0] v;
        if (!mode) begin
            v = gfInv(x);
            return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                     ^ {v[3:0], v[7:4]} ^ 8'h63;
        end
        v = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gfInv(v);
    endfunction

    assign w_accept   = bus.in_valid & w_inReady;
    assign w_lastBeat = (r_cnt == CW'(BEATS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A DONE hand-off with a waiting block goes straight back to BUSY, avoiding an IDLE bubble.
    always_comb begin
        w_nextState = r_state;
        w_inReady   = 1'b0;
        w_outValid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_inReady = 1'b1;
                if (bus.in_valid) w_nextState = BUSY;
            end
            BUSY: begin
                if (w_lastBeat) w_nextState = DONE;
            end
            DONE: begin
                w_outValid = 1'b1;
                w_inReady  = bus.out_ready;
                if (bus.out_ready) w_nextState = bus.in_valid ? BUSY : IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Each lane picks its byte of the current beat from the latched block.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_laneIn[l] = 8'h00;
            for (int k = 0; k < BEATS; k++) begin
                if (r_cnt == CW'(k)) w_laneIn[l] = r_data[SIZE*8-1-8*(k*LANES+l) -: 8];
            end
            w_laneOut[l] = sbox(r_mode, w_laneIn[l]);
        end
    end

    // A back-to-back accept keeps the previous result visible until its bytes are overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_data   <= '0;
            r_result <= '0;
            r_mode   <= 1'b0;
        end else if (w_accept) begin
            r_data <= bus.block;
            r_mode <= bus.inv;
            r_cnt  <= '0;
            if (r_state == IDLE) r_result <= '0;
        end else if (r_state == BUSY) begin
            for (int b = 0; b < SIZE; b++) begin
                if (r_cnt == CW'(b / LANES)) r_result[SIZE*8-1-8*b -: 8] <= w_laneOut[b % LANES];
            end
            r_cnt <= w_lastBeat ? '0 : r_cnt + 1'b1;
        end
    end

    assign bus.in_ready    = w_inReady;
    assign bus.out_valid   = w_outValid;
    assign bus.subed_block = r_result;
endmodule
